zcu216_mmcm_drp_ctrl: RTL and testbench

ZCU216_MMCM_DRP_CTRL -- requirements
Module: zcu216_mmcm_drp_ctrl

---
 rtl/zcu216_mmcm_drp_ctrl.sv | 151 +++++++++++++++
 tb/tb_zcu216_mmcm_drp_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zcu216_mmcm_drp_ctrl.sv
// DRP reconfiguration sequencer for a ZCU216 MMCM. It holds the MMCM in reset,
// applies a table of masked read-modify-write updates, then releases reset and waits for lock.
module zcu216_mmcm_drp_ctrl #(
  parameter int NUM_REGS     = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 8,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [6:0]       cfg_addr,
  input  logic [15:0]      cfg_mask,
  input  logic [15:0]      cfg_data,
  input  logic [4:0]       cfg_len,
  output logic [6:0]       daddr,
  output logic [15:0]      di,
  output logic             den,
  output logic             dwe,
  input  logic [15:0]      do_i,
  input  logic             drdy,
  output logic             mmcm_rst,
  input  logic             mmcm_locked,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             lock_lost
);

  localparam int LEN_W    = $clog2(NUM_REGS + 1);
  localparam int CNT_MAX0 = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (RST_HOLD > CNT_MAX0) ? RST_HOLD : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE, RST_ASSERT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RST_RELEASE, LOCK_WAIT
  } state_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } entry_t;

  state_t           state, state_nxt;
  entry_t           tbl [NUM_REGS];
  entry_t           cur;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] idx, idx_inc, len, len_clamp;
  logic             armed, locked_q;
  logic             hold_end, drdy_to, lock_to, drp_to_hit, lock_to_hit;

  assign cur       = tbl[idx[IDX_W-1:0]];
  assign idx_inc   = idx + LEN_W'(1);
  assign len_clamp = (cfg_len > 5'(NUM_REGS)) ? LEN_W'(NUM_REGS) : cfg_len[LEN_W-1:0];

  assign hold_end    = cnt >= CNT_W'(RST_HOLD - 1);
  assign drdy_to     = cnt >= CNT_W'(DRDY_TIMEOUT - 1);
  assign lock_to     = cnt >= CNT_W'(LOCK_TIMEOUT - 1);
  assign drp_to_hit  = (state == RD_WAIT || state == WR_WAIT) && !drdy && drdy_to;
  assign lock_to_hit = (state == LOCK_WAIT) && !mmcm_locked && lock_to;

  // NOTE: the table has no reset; its contents are don't-care after rst, and
  // leaving it out of the reset tree lets it map onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE)
      tbl[cfg_idx] <= '{addr: cfg_addr, mask: cfg_mask, data: cfg_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = RST_ASSERT;
      RST_ASSERT:  if (hold_end) state_nxt = (len != '0) ? RD_REQ : RST_RELEASE;
      RD_REQ:      state_nxt = RD_WAIT;
      RD_WAIT:     if (drdy) state_nxt = WR_REQ;
                   else if (drdy_to) state_nxt = IDLE;
      WR_REQ:      state_nxt = WR_WAIT;
      WR_WAIT:     if (drdy) state_nxt = (idx_inc == len) ? RST_RELEASE : RD_REQ;
                   else if (drdy_to) state_nxt = IDLE;
      RST_RELEASE: state_nxt = LOCK_WAIT;
      LOCK_WAIT:   if (mmcm_locked || lock_to) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    den   = 1'b0;
    dwe   = 1'b0;
    daddr = '0;
    busy  = (state != IDLE);
    case (state)
      RD_REQ:  begin den = 1'b1; daddr = cur.addr; end
      WR_REQ:  begin den = 1'b1; dwe = 1'b1; daddr = cur.addr; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      len       <= '0;
      di        <= '0;
      mmcm_rst  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      lock_lost <= 1'b0;
      armed     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      // One saturating counter serves reset hold, DRP wait and lock wait; it restarts on every state change.
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);

      locked_q <= mmcm_locked;
      done     <= (state == LOCK_WAIT) && mmcm_locked;

      if (state == IDLE && start) begin
        idx       <= '0;
        len       <= len_clamp;
        error     <= 1'b0;
        lock_lost <= 1'b0;
        armed     <= 1'b0;
      end else begin
        if (state == RD_WAIT && drdy) di <= (do_i & cur.mask) | cur.data;
        if (state == WR_WAIT && drdy) idx <= idx_inc;
        if (drp_to_hit || lock_to_hit) error <= 1'b1;
        if (state == LOCK_WAIT && mmcm_locked) armed <= 1'b1;
        if (state == IDLE && armed && locked_q && !mmcm_locked) lock_lost <= 1'b1;
      end

      // A DRP timeout returns to IDLE without passing RST_RELEASE, so the MMCM stays in reset.
      if (state_nxt == RST_ASSERT)       mmcm_rst <= 1'b1;
      else if (state_nxt == RST_RELEASE) mmcm_rst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zcu216_mmcm_drp_ctrl.sv
// Scoreboard bench for zcu216_mmcm_drp_ctrl: directed sequences push expected DRP
// accesses and completions; a monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_zcu216_mmcm_drp_ctrl;

  localparam int NUM_REGS     = 8;
  localparam int DRDY_TIMEOUT = 255;
  localparam int LOCK_TIMEOUT = 65535;
  localparam int RST_HOLD     = 8;
  localparam int KIND_DONE    = 0;
  localparam int KIND_ERROR   = 1;

  logic        clk, rst, start, cfg_we;
  logic [2:0]  cfg_idx;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_mask, cfg_data;
  logic [4:0]  cfg_len;
  logic [6:0]  daddr;
  logic [15:0] di, do_i;
  logic        den, dwe, drdy, mmcm_rst, mmcm_locked;
  logic        busy, done, error, lock_lost;

  zcu216_mmcm_drp_ctrl #(
    .NUM_REGS(NUM_REGS), .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .daddr(daddr), .di(di), .den(den), .dwe(dwe), .do_i(do_i), .drdy(drdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked), .busy(busy), .done(done),
    .error(error), .lock_lost(lock_lost)
  );

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } drp_exp_t;

  drp_exp_t    drp_q[$];
  int          cmp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [15:0] drp_mem [128];
  int          drp_lat  = 3;
  bit          drp_dead = 0;
  bit          lock_en  = 1;
  int          lock_delay = 50;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_rd(input logic [6:0] a);
    drp_q.push_back('{we: 1'b0, addr: a, data: 16'h0});
  endtask

  task automatic exp_wr(input logic [6:0] a, input logic [15:0] d);
    drp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  // DRP slave: answers each den after drp_lat cycles from a small register file.
  initial begin : drp_model
    int cnt;
    logic pend_we;
    logic [6:0] pend_addr;
    logic [15:0] pend_di;
    cnt = 0; pend_we = 1'b0; pend_addr = '0; pend_di = '0;
    drdy = 1'b0; do_i = '0;
    forever begin
      @(posedge clk); #2;
      drdy = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            drdy = 1'b1;
            if (pend_we) drp_mem[pend_addr] = pend_di;
            else         do_i = drp_mem[pend_addr];
          end
        end
        if (den && !drp_dead) begin
          cnt = drp_lat; pend_we = dwe; pend_addr = daddr; pend_di = di;
        end
      end
    end
  end

  // MMCM lock model: locks lock_delay cycles after reset release while lock_en is set.
  initial begin : lock_model
    int lcnt;
    lcnt = 0;
    mmcm_locked = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (mmcm_rst || !lock_en) begin
        lcnt = 0; mmcm_locked = 1'b0;
      end else begin
        if (lcnt < lock_delay) lcnt++;
        mmcm_locked = (lcnt >= lock_delay);
      end
    end
  end

  initial begin : monitor
    bit pending, err_prev;
    drp_exp_t e;
    pending = 0; err_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 0; err_prev = 0;
      end else begin
        if (den) begin
          check("den_overlap", 32'(pending), 32'd0);
          check("den_mmcm_rst", 32'(mmcm_rst), 32'd1);
          if (drp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL drp_unexpected_den: got we=%0b addr=0x%0h expected no access", dwe, daddr);
          end else begin
            e = drp_q.pop_front();
            check("drp_dwe", 32'(dwe), 32'(e.we));
            check("drp_daddr", 32'(daddr), 32'(e.addr));
            if (e.we) check("drp_di", 32'(di), 32'(e.data));
          end
          pending = 1;
        end else if (drdy || !busy) pending = 0;
        if (done) begin
          done_cnt++;
          if (cmp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_done: got done=1 expected none");
          end else check("completion_kind", KIND_DONE, cmp_q.pop_front());
        end
        if (error && !err_prev) begin
          if (cmp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_error: got error=1 expected none");
          end else check("completion_kind", KIND_ERROR, cmp_q.pop_front());
        end
        err_prev = error;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: got no end of test expected finish before 1.5ms");
    $fatal(1, "watchdog expired");
  end

  task automatic wr_entry(input logic [2:0] i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_mask = m; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input logic [4:0] n);
    @(posedge clk); #1;
    start = 1'b1; cfg_len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    #1;
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int n, d0;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_addr = '0; cfg_mask = '0; cfg_data = '0; cfg_len = '0;
    for (int i = 0; i < 128; i++) drp_mem[i] = 16'hFFFF;

    // Reset values, and mmcm_rst still held after rst release
    repeat (3) @(posedge clk); #1;
    check("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("rst_den", 32'(den), 32'd0);
    check("rst_dwe", 32'(dwe), 32'd0);
    check("rst_daddr", 32'(daddr), 32'd0);
    check("rst_di", 32'(di), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_mmcm_rst_held", 32'(mmcm_rst), 32'd1);

    // Single entry: read 0xFFFF, write (0xFFFF & 0x1000) | 0x0041 = 0x1041
    wr_entry(3'd0, 7'h08, 16'h1000, 16'h0041);
    exp_rd(7'h08); exp_wr(7'h08, 16'h1041); cmp_q.push_back(KIND_DONE);
    d0 = done_cnt;
    start_seq(5'd1);
    check("a_busy_after_start", 32'(busy), 32'd1);
    wait_idle("a", 500);
    check("a_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("a_mmcm_rst_low", 32'(mmcm_rst), 32'd0);
    check("a_error", 32'(error), 32'd0);
    check("a_mem08", 32'(drp_mem[8'h08]), 32'h1041);

    // Three entries, last one written in the start cycle; writes/start while busy ignored
    drp_mem[7'h08] = 16'hFFFF; drp_mem[7'h09] = 16'h1234; drp_mem[7'h14] = 16'hA5A5;
    wr_entry(3'd0, 7'h08, 16'h1000, 16'h0041);
    wr_entry(3'd1, 7'h09, 16'hFF00, 16'h0012);
    exp_rd(7'h08); exp_wr(7'h08, 16'h1041);
    exp_rd(7'h09); exp_wr(7'h09, 16'h1212);
    exp_rd(7'h14); exp_wr(7'h14, 16'h5555);
    cmp_q.push_back(KIND_DONE);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 5'd3;
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_addr = 7'h14; cfg_mask = 16'h0F0F; cfg_data = 16'h5050;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 5'd0;
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_addr = 7'h55; cfg_mask = 16'h0000; cfg_data = 16'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    wait_idle("b", 2000);
    check("b_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("b_mem09", 32'(drp_mem[7'h09]), 32'h1212);
    check("b_mem14", 32'(drp_mem[7'h14]), 32'h5555);

    // DRP never answers: error 256 cycles after the read den, mmcm_rst stays high
    drp_dead = 1;
    wr_entry(3'd0, 7'h0A, 16'h0000, 16'h0001);
    exp_rd(7'h0A); cmp_q.push_back(KIND_ERROR);
    d0 = done_cnt;
    start_seq(5'd1);
    n = 0;
    while (!den && n < 100) begin @(negedge clk); n++; end
    check("c_den_seen", 32'(den), 32'd1);
    n = 0;
    while (!error && n < 1000) begin @(negedge clk); n++; end
    check("c_drdy_timeout_cycles", 32'(n), 32'(DRDY_TIMEOUT + 1));
    wait_idle("c", 10);
    check("c_mmcm_rst_high", 32'(mmcm_rst), 32'd1);
    check("c_no_done", 32'(done_cnt - d0), 32'd0);
    drp_dead = 0;

    // Lock never arrives: error LOCK_TIMEOUT cycles into LOCK_WAIT, mmcm_rst low
    lock_en = 0;
    cmp_q.push_back(KIND_ERROR);
    d0 = done_cnt;
    start_seq(5'd0);
    n = 0;
    while (mmcm_rst && n < 100) begin @(negedge clk); n++; end
    check("d_mmcm_rst_released", 32'(mmcm_rst), 32'd0);
    n = 0;
    while (!error && n < 70000) begin @(negedge clk); n++; end
    check("d_lock_timeout_cycles", 32'(n), 32'(LOCK_TIMEOUT + 1));
    wait_idle("d", 10);
    check("d_mmcm_rst_low", 32'(mmcm_rst), 32'd0);
    check("d_no_done", 32'(done_cnt - d0), 32'd0);

    // Empty table: error cleared by start, RST_HOLD-cycle reset pulse, done, then lock loss
    lock_en = 1;
    cmp_q.push_back(KIND_DONE);
    d0 = done_cnt;
    start_seq(5'd0);
    check("e_error_cleared", 32'(error), 32'd0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!mmcm_rst) break;
      n++;
    end
    check("e_rst_pulse_cycles", 32'(n), 32'(RST_HOLD));
    wait_idle("e", 500);
    check("e_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("e_lock_lost_before", 32'(lock_lost), 32'd0);
    lock_en = 0;
    repeat (3) @(negedge clk);
    check("e_lock_lost_set", 32'(lock_lost), 32'd1);
    lock_en = 1;

    // rst during WR_WAIT aborts at once; a fresh start completes
    drp_lat = 10;
    drp_mem[7'h10] = 16'h1234;
    wr_entry(3'd0, 7'h10, 16'hFF00, 16'h00AA);
    exp_rd(7'h10); exp_wr(7'h10, 16'h12AA);
    start_seq(5'd1);
    check("f_lock_lost_cleared", 32'(lock_lost), 32'd0);
    n = 0;
    while (!(den && dwe) && n < 200) begin @(negedge clk); n++; end
    check("f_write_seen", 32'(den && dwe), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("f_rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("f_rst_den", 32'(den), 32'd0);
    check("f_rst_daddr", 32'(daddr), 32'd0);
    check("f_rst_di", 32'(di), 32'd0);
    check("f_rst_busy", 32'(busy), 32'd0);
    check("f_rst_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    drp_lat = 3;
    wr_entry(3'd0, 7'h10, 16'hFF00, 16'h00AA);
    exp_rd(7'h10); exp_wr(7'h10, 16'h12AA); cmp_q.push_back(KIND_DONE);
    d0 = done_cnt;
    start_seq(5'd1);
    wait_idle("f", 500);
    check("f_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("f_mem10", 32'(drp_mem[7'h10]), 32'h12AA);

    repeat (3) @(negedge clk);
    check("drp_q_drained", 32'(drp_q.size()), 32'd0);
    check("cmp_q_drained", 32'(cmp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
